// File: rtl/product_histogram.sv
// product_histogram
//   Builds a 16-bin histogram of the 4-bit products delivered by an upstream
//   2x2 multiplier. A window of WINDOW products is collected after start. The
//   bins are then read out one per handshake, with the bin index as the
//   product value. A product that a 2x2 multiplier can never produce raises a
//   sticky error flag.
//
// Parameters
//   WINDOW    products accepted per measurement window (1..65535)
//   CNT_W     width of each bin counter (saturating)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a new window (only honoured while idle)
//   s_valid    in   product on s is valid
//   s          in   4-bit unsigned product
//   s_ready    out  a product is accepted this cycle when s_valid is high
//   bin_valid  out  bin_idx/bin_count hold a readout bin
//   bin_idx    out  index of the bin being read out
//   bin_count  out  count of bin_idx in the last window
//   bin_ready  in   downstream consumes the presented bin
//   done       out  one-cycle pulse after the last bin is consumed
//   busy       out  collecting or dumping
//   err        out  an impossible product was accepted in this window
module product_histogram #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic [3:0]       s,
  output logic             s_ready,
  output logic             bin_valid,
  output logic [3:0]       bin_idx,
  output logic [CNT_W-1:0] bin_count,
  input  logic             bin_ready,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DUMP    = 2'd2
  } state_t;

  // Products of two 2-bit operands are only 0,1,2,3,4,6,9. A set bit marks a
  // value that cannot come from the multiplier.
  localparam logic [15:0]      IMPOSSIBLE_MASK = 16'hFDA0;
  localparam logic [15:0]      LAST_SAMPLE     = 16'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX         = '1;

  state_t           state_reg, state_next;
  logic [15:0]      sample_cnt_reg;
  logic [3:0]       bin_idx_reg;
  logic             err_reg;
  logic             done_reg;
  logic [CNT_W-1:0] bin_q [16];

  logic clear;     // start honoured: wipe the previous window
  logic accept;    // product handshake
  logic consume;   // readout handshake
  logic last_bin;  // handshake on bin 15 ends the readout

  assign clear    = (state_reg == IDLE) && start;
  assign accept   = (state_reg == COLLECT) && s_valid;
  assign consume  = (state_reg == DUMP) && bin_ready;
  assign last_bin = consume && (bin_idx_reg == 4'd15);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    bin_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        s_ready = 1'b1;
        if (accept && (sample_cnt_reg == LAST_SAMPLE)) begin
          state_next = DUMP;
        end
      end
      DUMP: begin
        bin_valid = 1'b1;
        if (last_bin) begin
          state_next = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Products accepted so far in this window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_reg <= '0;
    end else if (clear) begin
      sample_cnt_reg <= '0;
    end else if (accept) begin
      sample_cnt_reg <= sample_cnt_reg + 16'd1;
    end
  end

  // Readout pointer. It wraps back to 0 after bin 15, ready for the next dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_idx_reg <= '0;
    end else if (clear) begin
      bin_idx_reg <= '0;
    end else if (consume) begin
      bin_idx_reg <= bin_idx_reg + 4'd1;
    end
  end

  // Sticky error flag and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= last_bin;
      if (clear) begin
        err_reg <= 1'b0;
      end else if (accept && IMPOSSIBLE_MASK[s]) begin
        err_reg <= 1'b1;
      end
    end
  end

  // One saturating counter per product value. The counters live in registers
  // because the readout must select a bin combinationally.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : gen_bin
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (accept && (s == 4'(gi)) && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign bin_q[gi] = cnt_reg;
    end
  endgenerate

  assign bin_idx   = bin_idx_reg;
  assign bin_count = bin_q[bin_idx_reg];
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_product_histogram.sv
// Testbench for product_histogram.
// Two instances share stimulus: dut_a (WINDOW=4, CNT_W=16) and dut_b
// (WINDOW=6, CNT_W=2). Each has its own start, so only the selected one runs.
// The reference model is a plain histogram array filled from the products the
// bench itself handed over. Outputs are sampled on the falling clock edge.
module tb_product_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start_a, start_b, s_valid, bin_ready;
  logic [3:0] s;

  logic        a_s_ready, a_bin_valid, a_done, a_busy, a_err;
  logic [3:0]  a_bin_idx;
  logic [15:0] a_bin_count;
  logic        b_s_ready, b_bin_valid, b_done, b_busy, b_err;
  logic [3:0]  b_bin_idx;
  logic [1:0]  b_bin_count;

  product_histogram #(.WINDOW(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .s_valid(s_valid), .s(s),
    .s_ready(a_s_ready), .bin_valid(a_bin_valid), .bin_idx(a_bin_idx),
    .bin_count(a_bin_count), .bin_ready(bin_ready), .done(a_done),
    .busy(a_busy), .err(a_err)
  );

  product_histogram #(.WINDOW(6), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .s_valid(s_valid), .s(s),
    .s_ready(b_s_ready), .bin_valid(b_bin_valid), .bin_idx(b_bin_idx),
    .bin_count(b_bin_count), .bin_ready(bin_ready), .done(b_done),
    .busy(b_busy), .err(b_err)
  );

  // Outputs of the instance under test
  int          sel = 0;
  logic        o_s_ready, o_bin_valid, o_done, o_busy, o_err;
  logic [3:0]  o_bin_idx;
  logic [15:0] o_bin_count;

  always_comb begin
    o_s_ready   = (sel == 1) ? b_s_ready   : a_s_ready;
    o_bin_valid = (sel == 1) ? b_bin_valid : a_bin_valid;
    o_done      = (sel == 1) ? b_done      : a_done;
    o_busy      = (sel == 1) ? b_busy      : a_busy;
    o_err       = (sel == 1) ? b_err       : a_err;
    o_bin_idx   = (sel == 1) ? b_bin_idx   : a_bin_idx;
    o_bin_count = (sel == 1) ? {14'd0, b_bin_count} : a_bin_count;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int hist [16];
  bit exp_err = 1'b0;
  int prod_q [$];
  int legal_vals [7] = '{0, 1, 2, 3, 4, 6, 9};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_impossible(input int v);
    return !(v inside {0, 1, 2, 3, 4, 6, 9});
  endfunction

  function automatic int sat(input int v, input int maxc);
    return (v > maxc) ? maxc : v;
  endfunction

  // Idle cycles with no start: nothing may move, and done must be low.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_done", o_done, 0);
      check("idle_busy", o_busy, 0);
      check("idle_s_ready", o_s_ready, 0);
      check("idle_bin_valid", o_bin_valid, 0);
      check("idle_err", o_err, exp_err);
    end
  endtask

  // One full window on instance dsel.
  //   mode 0: random valid/products, 1: all-valid from prod_q, 2: valid toggling with s=6
  //   hold:   keep start high for the whole window
  //   rdy_all: bin_ready tied high during readout
  task automatic run_window(input int dsel, input int mode, input bit hold, input bit rdy_all);
    int win, maxc, acc, idx, pi, cyc, dcyc;
    bit tog;
    sel  = dsel;
    win  = (dsel == 1) ? 6 : 4;
    maxc = (dsel == 1) ? 3 : 65535;
    if (dsel == 1) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    foreach (hist[i]) hist[i] = 0;
    exp_err = 1'b0;
    acc = 0; pi = 0; cyc = 0; tog = 1'b1;

    while (acc < win) begin
      check("col_busy", o_busy, 1);
      check("col_s_ready", o_s_ready, 1);
      check("col_bin_valid", o_bin_valid, 0);
      check("col_done", o_done, 0);
      check("col_err", o_err, exp_err);
      case (mode)
        1: begin
          s_valid = 1'b1;
          s = (pi < prod_q.size()) ? 4'(prod_q[pi]) : 4'd0;
          pi++;
        end
        2: begin
          s_valid = tog;
          s = 4'd6;
          tog = !tog;
        end
        default: begin
          s_valid = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 7) == 0) s = 4'($urandom_range(0, 15));
          else s = 4'(legal_vals[$urandom_range(0, 6)]);
        end
      endcase
      bin_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (s_valid) begin
        acc++;
        hist[s]++;
        if (is_impossible(int'(s))) exp_err = 1'b1;
      end
    end
    s_valid = 1'b0;
    if (mode == 2) check("toggle_accept_cycles", cyc, 7);

    idx = 0; dcyc = 0;
    while (idx < 16) begin
      check("dump_busy", o_busy, 1);
      check("dump_s_ready", o_s_ready, 0);
      check("dump_bin_valid", o_bin_valid, 1);
      check("dump_bin_idx", o_bin_idx, idx);
      check("dump_bin_count", o_bin_count, sat(hist[idx], maxc));
      check("dump_done", o_done, 0);
      check("dump_err", o_err, exp_err);
      bin_ready = rdy_all ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      dcyc++;
      if (bin_ready) idx++;
    end
    bin_ready = 1'b0;
    if (rdy_all) check("dump_cycles", dcyc, 16);
    check("end_done", o_done, 1);
    check("end_busy", o_busy, 0);
    check("end_bin_valid", o_bin_valid, 0);
    check("end_s_ready", o_s_ready, 0);
    check("end_err", o_err, exp_err);
    $display("window dut=%0d mode=%0d hold=%0d accepts=%0d collect_cycles=%0d dump_cycles=%0d err=%0d",
             dsel, mode, hold, acc, cyc, dcyc, exp_err);
  endtask

  // Stall the readout, then hit the asynchronous reset between clock edges.
  task automatic reset_mid_dump();
    sel = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    prod_q = '{3, 3, 5, 9};
    foreach (prod_q[i]) begin
      s_valid = 1'b1;
      s = 4'(prod_q[i]);
      @(negedge clk);
    end
    s_valid = 1'b0;
    bin_ready = 1'b1;
    repeat (3) @(negedge clk);
    bin_ready = 1'b0;
    repeat (5) begin
      check("stall_bin_idx", o_bin_idx, 3);
      check("stall_bin_count", o_bin_count, 2);
      check("stall_bin_valid", o_bin_valid, 1);
      check("stall_err", o_err, 1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_state_busy", o_busy, 0);
    check("arst_s_ready", o_s_ready, 0);
    check("arst_bin_valid", o_bin_valid, 0);
    check("arst_bin_idx", o_bin_idx, 0);
    check("arst_bin_count", o_bin_count, 0);
    check("arst_done", o_done, 0);
    check("arst_err", o_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
    $display("reset mid-dump at bin 3 after 5 stalled cycles");
    idle(4);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    s_valid = 1'b0; s = 4'd0; bin_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_s_ready", o_s_ready, 0);
      check("rst_bin_valid", o_bin_valid, 0);
      check("rst_bin_idx", o_bin_idx, 0);
      check("rst_bin_count", o_bin_count, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Back-to-back legal products, full-speed readout
    prod_q = '{0, 1, 4, 9};
    run_window(0, 1, 1'b0, 1'b1);
    idle(1);

    // Valid toggling: four accepts over seven cycles
    run_window(0, 2, 1'b0, 1'b1);
    idle(1);

    // Impossible product sets err; it survives into idle and clears on start
    prod_q = '{7, 2, 0, 0};
    run_window(0, 1, 1'b0, 1'b0);
    idle(1);

    // Saturation of a 2-bit counter
    prod_q = '{3, 3, 3, 3, 3, 3};
    run_window(1, 1, 1'b0, 1'b1);
    idle(1);

    // Randomized windows on both instances
    repeat (8) begin
      run_window(int'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
      idle(int'($urandom_range(1, 3)));
    end

    // start held high: one window completes, the next begins right after done
    run_window(0, 0, 1'b1, 1'b0);
    run_window(0, 0, 1'b0, 1'b0);
    idle(1);

    reset_mid_dump();

    // Normal operation after the abandoned window
    run_window(1, 0, 1'b0, 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_histogram.md
PRODUCT_HISTOGRAM -- requirements
Module: product_histogram

Interface
REQ-001 Parameter WINDOW, default 256: number of products accepted per measurement window; legal range 1..65535.
REQ-002 Parameter CNT_W, default 16: width of each bin counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new measurement window; sampled only in IDLE.
REQ-006 s_valid  input  1  upstream 2x2 multiplier product on s is valid.
REQ-007 s  input  4  unsigned product a*b from the upstream multiplier.
REQ-008 s_ready  output  1  block accepts a product this cycle.
REQ-009 bin_valid  output  1  readout bin presented on bin_idx/bin_count.
REQ-010 bin_idx  output  4  bin index (product value) being read out.
REQ-011 bin_count  output  CNT_W  occurrences of bin_idx in the last window.
REQ-012 bin_ready  input  1  downstream consumes the presented bin.
REQ-013 done  output  1  one-cycle pulse when the last bin is consumed.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err  output  1  sticky: an impossible product (5,7,8,10..15) was accepted in the current window.

Function
REQ-016 States SHALL be IDLE, COLLECT, DUMP; encoding is free.
REQ-017 IDLE: s_ready=0, bin_valid=0; on start=1, go to COLLECT next cycle, clearing all 16 bins, the sample counter and err in that same edge.
REQ-018 COLLECT: s_ready=1; a product is accepted on any edge with s_valid=1 && s_ready=1.
REQ-019 Each acceptance SHALL increment bin[s] by one; the bin SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Each acceptance SHALL increment the sample counter; the acceptance making it equal WINDOW SHALL move the FSM to DUMP on that edge, and s_ready SHALL be 0 from the next cycle.
REQ-021 Accepting s in {5,7,8,10,11,12,13,14,15} SHALL set err; err is still counted into its bin; err clears only on start-in-IDLE or reset.
REQ-022 s_valid=0 cycles in COLLECT SHALL change nothing (no timeout).
REQ-023 DUMP: bin_valid=1, bin_idx starts at 0; on bin_valid && bin_ready, bin_idx increments by one; bin_idx/bin_count SHALL hold stable while bin_ready=0.
REQ-024 Consumption of bin_idx=15 SHALL return the FSM to IDLE and assert done for exactly that following cycle; bins retain their values until the next start.
REQ-025 start outside IDLE SHALL be ignored; start asserted in the cycle the FSM reaches IDLE is acted on the next cycle.
REQ-026 bin_count SHALL be combinationally selected from the bin register array (zero-cycle readout latency).
REQ-027 busy SHALL be 1 in COLLECT and DUMP, 0 in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately, without clock, force: state IDLE, all bins 0, sample counter 0, bin_idx 0, s_ready 0, bin_valid 0, done 0, busy 0, err 0.
REQ-029 Reset asserted mid-COLLECT or mid-DUMP SHALL abandon the window; no done pulse; a fresh start is required afterwards.
REQ-030 Release of rst_n SHALL take effect at the first rising clk edge with rst_n=1; no state change before it.

Verification
REQ-031 WINDOW=4, start, then s=0,1,4,9 back-to-back, bin_ready=1 -> 16 bins read in 16 cycles: bins 0,1,4,9 =1, all others 0; done pulses once; err=0.
REQ-032 WINDOW=4, s_valid toggled 1,0,1,0,... with s=6 -> exactly 4 accepts over 7 cycles; bin 6 =4; s_ready drops the cycle after the 4th accept.
REQ-033 CNT_W=2, WINDOW=6, s=3 six times -> bin 3 reads 3 (saturated), no wrap.
REQ-034 WINDOW=2, s=7 then s=2 -> err=1 from the cycle after the first accept; bin 7 =1, bin 2 =1; err clears on next start.
REQ-035 In DUMP hold bin_ready=0 for 5 cycles at bin_idx=3 -> bin_idx/bin_count stable; then pulse rst_n=0 asynchronously mid-cycle -> all outputs 0 before next edge, no done.
REQ-036 start held high through an entire window -> only one window runs until IDLE, then a second window starts the following cycle with bins cleared.
